// File: rtl/parse_act_ram_loader.sv
// Parser action RAM loader: assembles one action entry from a config packet
// (header + MSW-first data words) and writes it through RAM port A.
module parse_act_ram_loader #(
    parameter int         C_WORD_WIDTH  = 32,
    parameter int         C_ENTRY_WIDTH = 160,
    parameter int         C_ADDR_WIDTH  = 5,
    parameter logic [7:0] C_MOD_ID      = 8'h01
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [C_WORD_WIDTH-1:0]  s_cfg_tdata,
    input  logic                     s_cfg_tvalid,
    input  logic                     s_cfg_tlast,
    output logic                     s_cfg_tready,
    output logic [C_ADDR_WIDTH-1:0]  ram_addra,
    output logic [C_ENTRY_WIDTH-1:0] ram_dina,
    output logic                     ram_wea,
    output logic                     wr_done,
    output logic                     err_pkt
);

    localparam int N_WORDS = C_ENTRY_WIDTH / C_WORD_WIDTH;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {S_HDR, S_DATA, S_WRITE, S_DROP} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [C_ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [C_ENTRY_WIDTH-1:0] entry_q, entry_d;
    logic                     tready_q, tready_d;
    logic [C_ADDR_WIDTH-1:0]  addra_q, addra_d;
    logic [C_ENTRY_WIDTH-1:0] dina_q, dina_d;
    logic                     wea_q, wea_d;
    logic                     wr_done_q, wr_done_d;
    logic                     err_q, err_d;

    logic                     hs;
    logic [7:0]               hdr_mod_id;
    logic [C_ENTRY_WIDTH-1:0] entry_shifted;

    assign hs            = s_cfg_tvalid & tready_q;
    assign hdr_mod_id    = s_cfg_tdata[C_WORD_WIDTH-1 -: 8];
    assign entry_shifted = {entry_q[C_ENTRY_WIDTH-C_WORD_WIDTH-1:0], s_cfg_tdata};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        entry_d   = entry_q;
        addra_d   = addra_q;
        dina_d    = dina_q;
        wea_d     = 1'b0;
        wr_done_d = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_HDR: begin
                if (hs) begin
                    if (hdr_mod_id == C_MOD_ID) begin
                        if (s_cfg_tlast) begin
                            err_d = 1'b1;
                        end else begin
                            idx_d   = s_cfg_tdata[C_ADDR_WIDTH-1:0];
                            cnt_d   = '0;
                            state_d = S_DATA;
                        end
                    end else if (!s_cfg_tlast) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    entry_d = entry_shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        if (s_cfg_tlast) begin
                            // Write strobe and data launch together so the RAM sees them in S_WRITE.
                            state_d   = S_WRITE;
                            addra_d   = idx_q;
                            dina_d    = entry_shifted;
                            wea_d     = 1'b1;
                            wr_done_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DROP;
                        end
                    end else if (s_cfg_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_HDR;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_HDR;
            end
            S_DROP: begin
                if (hs && s_cfg_tlast) begin
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase

        tready_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            cnt_q     <= '0;
            idx_q     <= '0;
            entry_q   <= '0;
            tready_q  <= 1'b0;
            addra_q   <= '0;
            dina_q    <= '0;
            wea_q     <= 1'b0;
            wr_done_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            entry_q   <= entry_d;
            tready_q  <= tready_d;
            addra_q   <= addra_d;
            dina_q    <= dina_d;
            wea_q     <= wea_d;
            wr_done_q <= wr_done_d;
            err_q     <= err_d;
        end
    end

    assign s_cfg_tready = tready_q;
    assign ram_addra    = addra_q;
    assign ram_dina     = dina_q;
    assign ram_wea      = wea_q;
    assign wr_done      = wr_done_q;
    assign err_pkt      = err_q;

endmodule

// File: tb/tb_parse_act_ram_loader.sv
// Self-checking bench for parse_act_ram_loader: directed scenarios plus random
// packets scored against a packet-level reference model.
`timescale 1ns/1ps
module tb_parse_act_ram_loader;

    typedef logic [31:0] word_q_t[$];
    typedef struct packed {
        logic [4:0]   a;
        logic [159:0] d;
    } wr_t;

    logic         clk;
    logic         rst_n;
    logic [31:0]  s_cfg_tdata;
    logic         s_cfg_tvalid;
    logic         s_cfg_tlast;
    logic         s_cfg_tready;
    logic [4:0]   ram_addra;
    logic [159:0] ram_dina;
    logic         ram_wea;
    logic         wr_done;
    logic         err_pkt;

    int checks = 0;
    int errors = 0;

    wr_t obs_wr[$];
    wr_t exp_wr[$];
    int  obs_err = 0;
    int  exp_err = 0;

    parse_act_ram_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_cfg_tdata  (s_cfg_tdata),
        .s_cfg_tvalid (s_cfg_tvalid),
        .s_cfg_tlast  (s_cfg_tlast),
        .s_cfg_tready (s_cfg_tready),
        .ram_addra    (ram_addra),
        .ram_dina     (ram_dina),
        .ram_wea      (ram_wea),
        .wr_done      (wr_done),
        .err_pkt      (err_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe RAM writes and error pulses mid-cycle
    always @(negedge clk) begin
        if (ram_wea === 1'b1) obs_wr.push_back('{a: ram_addra, d: ram_dina});
        if (err_pkt === 1'b1) obs_err++;
        if (ram_wea === 1'b1 || wr_done === 1'b1) begin
            checks++;
            if (ram_wea !== wr_done) begin
                errors++;
                $display("[TB] FAIL wr_done_vs_wea: wr_done=%b required=%b", wr_done, ram_wea);
            end
        end
    end

    // Packet-level reference: only a correctly sized packet for our module ID writes
    function automatic void model_pkt(input word_q_t w);
        logic [159:0] d;
        logic [31:0]  h;
        if (w.size() == 0) return;
        h = w[0];
        if (h[31:24] != 8'h01) return;
        if (w.size() != 6) begin
            exp_err++;
            return;
        end
        d = '0;
        for (int i = 1; i < 6; i++) d = {d[127:0], w[i]};
        exp_wr.push_back('{a: h[4:0], d: d});
    endfunction

    task automatic idle(input int n);
        s_cfg_tvalid = 1'b0;
        s_cfg_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns #1 after the handshake edge; tvalid is left high
    task automatic send_word(input logic [31:0] w, input logic last, input int max_gap, output int stalls);
        int g;
        stalls = 0;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        if (g > 0) idle(g);
        s_cfg_tdata  = w;
        s_cfg_tlast  = last;
        s_cfg_tvalid = 1'b1;
        while (s_cfg_tready !== 1'b1) begin
            @(posedge clk);
            #1;
            stalls++;
            if (stalls > 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake_timeout: stalls=%0d required<=20", stalls);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input word_q_t words, input int max_gap, input bit drop_after, output int first_stall);
        int st;
        first_stall = 0;
        foreach (words[i]) begin
            send_word(words[i], (i == words.size() - 1), max_gap, st);
            if (i == 0) first_stall = st;
        end
        if (drop_after) begin
            s_cfg_tvalid = 1'b0;
            s_cfg_tlast  = 1'b0;
        end
    endtask

    function automatic word_q_t make_pkt(input logic [7:0] mid, input logic [4:0] idx, input int ndata);
        word_q_t w;
        w.push_back({mid, 19'($urandom), idx});
        for (int i = 0; i < ndata; i++) w.push_back($urandom);
        return w;
    endfunction

    task automatic test_reset();
        s_cfg_tvalid = 1'b0;
        s_cfg_tlast  = 1'b0;
        s_cfg_tdata  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_cfg_tready, ram_wea, wr_done, err_pkt} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got=%b required=0000", {s_cfg_tready, ram_wea, wr_done, err_pkt});
        end
        checks++;
        if (ram_addra !== 5'd0 || ram_dina !== 160'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: addra=%0d dina=%h required 0/0", ram_addra, ram_dina);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (s_cfg_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tready_before_edge: got=%b required=0", s_cfg_tready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_cfg_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tready_after_edge: got=%b required=1", s_cfg_tready);
        end
    endtask

    task automatic test_basic_write();
        word_q_t w;
        int st;
        logic [159:0] exp_d;
        exp_d = 160'h11111111_22222222_33333333_44444444_55555555;
        w = '{32'h0100_0003, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        obs_wr.delete();
        send_pkt(w, 0, 1, st);
        checks++;
        if (ram_wea !== 1'b1 || wr_done !== 1'b1 || s_cfg_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_strobe: wea=%b done=%b tready=%b required 1/1/0", ram_wea, wr_done, s_cfg_tready);
        end
        checks++;
        if (ram_addra !== 5'd3 || ram_dina !== exp_d) begin
            errors++;
            $display("[TB] FAIL basic_data: addra=%0d dina=%h required 3/%h", ram_addra, ram_dina, exp_d);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ram_wea !== 1'b0 || s_cfg_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_one_cycle: wea=%b tready=%b required 0/1", ram_wea, s_cfg_tready);
        end
        idle(3);
        checks++;
        if (ram_addra !== 5'd3 || ram_dina !== exp_d || obs_wr.size() != 1) begin
            errors++;
            $display("[TB] FAIL basic_hold: addra=%0d writes=%0d required 3/1", ram_addra, obs_wr.size());
        end
    endtask

    task automatic test_foreign();
        word_q_t w;
        int st;
        int total_stall;
        obs_wr.delete();
        obs_err = 0;
        total_stall = 0;
        w = make_pkt(8'h02, 5'd4, 5);
        foreach (w[i]) begin
            send_word(w[i], (i == w.size() - 1), 0, st);
            total_stall += st;
        end
        idle(3);
        checks++;
        if (total_stall != 0) begin
            errors++;
            $display("[TB] FAIL foreign_tready: stalls=%0d required=0", total_stall);
        end
        checks++;
        if (obs_wr.size() != 0 || obs_err != 0) begin
            errors++;
            $display("[TB] FAIL foreign_ignored: writes=%0d errs=%0d required 0/0", obs_wr.size(), obs_err);
        end
    endtask

    task automatic test_short();
        word_q_t w;
        int st;
        obs_wr.delete();
        obs_err = 0;
        w = make_pkt(8'h01, 5'd7, 3);
        send_pkt(w, 0, 1, st);
        checks++;
        if (err_pkt !== 1'b1 || ram_wea !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_err: err=%b wea=%b required 1/0", err_pkt, ram_wea);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_pkt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL short_err_pulse: err=%b required=0", err_pkt);
        end
        exp_wr.delete();
        w = make_pkt(8'h01, 5'd7, 5);
        model_pkt(w);
        send_pkt(w, 1, 1, st);
        idle(2);
        checks++;
        if (obs_wr.size() != 1 || obs_err != 1 || obs_wr[0] !== exp_wr[0]) begin
            errors++;
            $display("[TB] FAIL short_recover: writes=%0d errs=%0d required 1/1 data match", obs_wr.size(), obs_err);
        end
    endtask

    task automatic test_long();
        word_q_t w;
        int st;
        obs_wr.delete();
        obs_err = 0;
        w = make_pkt(8'h01, 5'd9, 7);
        for (int i = 0; i < 6; i++) send_word(w[i], 1'b0, 0, st);
        checks++;
        if (err_pkt !== 1'b1 || ram_wea !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_err: err=%b wea=%b required 1/0", err_pkt, ram_wea);
        end
        send_word(w[6], 1'b0, 0, st);
        send_word(w[7], 1'b1, 0, st);
        idle(1);
        exp_wr.delete();
        w = make_pkt(8'h01, 5'd12, 5);
        model_pkt(w);
        send_pkt(w, 0, 1, st);
        idle(2);
        checks++;
        if (obs_wr.size() != 1 || obs_err != 1 || obs_wr[0] !== exp_wr[0]) begin
            errors++;
            $display("[TB] FAIL long_recover: writes=%0d errs=%0d required 1/1 data match", obs_wr.size(), obs_err);
        end
    endtask

    task automatic test_back_to_back();
        word_q_t a;
        word_q_t b;
        wr_t first_run[$];
        int st;
        obs_wr.delete();
        exp_wr.delete();
        a = make_pkt(8'h01, 5'd1, 5);
        b = make_pkt(8'h01, 5'd2, 5);
        model_pkt(a);
        model_pkt(b);
        send_pkt(a, 0, 0, st);
        send_pkt(b, 0, 1, st);
        checks++;
        if (st != 1) begin
            errors++;
            $display("[TB] FAIL b2b_bubble: stall=%0d required=1", st);
        end
        idle(3);
        checks++;
        if (obs_wr.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: writes=%0d required=2", obs_wr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_wr[i] !== exp_wr[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_write%0d: addr=%0d required=%0d", i, obs_wr[i].a, exp_wr[i].a);
                end
            end
        end
        first_run = obs_wr;
        obs_wr.delete();
        send_pkt(a, 3, 1, st);
        send_pkt(b, 3, 1, st);
        idle(3);
        checks++;
        if (obs_wr.size() != 2 || first_run.size() != 2 || obs_wr[0] !== first_run[0] || obs_wr[1] !== first_run[1]) begin
            errors++;
            $display("[TB] FAIL b2b_gapped: writes=%0d required identical 2", obs_wr.size());
        end
    endtask

    task automatic test_reset_mid();
        word_q_t w;
        int st;
        obs_wr.delete();
        obs_err = 0;
        exp_wr.delete();
        w = make_pkt(8'h01, 5'd4, 5);
        for (int i = 0; i < 4; i++) send_word(w[i], 1'b0, 0, st);
        rst_n = 1'b0;
        s_cfg_tvalid = 1'b0;
        #1;
        checks++;
        if ({s_cfg_tready, ram_wea, err_pkt} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: got=%b required=000", {s_cfg_tready, ram_wea, err_pkt});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        w = make_pkt(8'h01, 5'd4, 5);
        model_pkt(w);
        send_pkt(w, 0, 1, st);
        idle(2);
        checks++;
        if (obs_wr.size() != 1 || obs_err != 0 || obs_wr[0] !== exp_wr[0]) begin
            errors++;
            $display("[TB] FAIL reset_mid_recover: writes=%0d errs=%0d required 1/0 data match", obs_wr.size(), obs_err);
        end
    endtask

    task automatic test_random();
        word_q_t w;
        int st;
        int nd;
        logic [7:0] mid;
        obs_wr.delete();
        exp_wr.delete();
        obs_err = 0;
        exp_err = 0;
        for (int p = 0; p < 60; p++) begin
            mid = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 255)) : 8'h01;
            nd  = ($urandom_range(0, 1) == 0) ? 5 : int'($urandom_range(0, 8));
            w = make_pkt(mid, 5'($urandom), nd);
            model_pkt(w);
            send_pkt(w, $urandom_range(0, 1) * 2, $urandom_range(0, 1), st);
        end
        idle(3);
        checks++;
        if (obs_err != exp_err) begin
            errors++;
            $display("[TB] FAIL rand_errs: got=%0d required=%0d", obs_err, exp_err);
        end
        checks++;
        if (obs_wr.size() != exp_wr.size()) begin
            errors++;
            $display("[TB] FAIL rand_count: got=%0d required=%0d", obs_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i]) begin
                checks++;
                if (obs_wr[i] !== exp_wr[i]) begin
                    errors++;
                    $display("[TB] FAIL rand_write%0d: addr=%0d dina=%h required %0d/%h", i, obs_wr[i].a, obs_wr[i].d, exp_wr[i].a, exp_wr[i].d);
                end
            end
        end
    endtask

    initial begin
        rst_n        = 1'b1;
        s_cfg_tvalid = 1'b0;
        s_cfg_tlast  = 1'b0;
        s_cfg_tdata  = '0;
        test_reset();
        test_basic_write();
        test_foreign();
        test_short();
        test_long();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
